// File: rtl/cpu_seq.sv
// Instruction sequencer: one-hot phase counter with ROM wait states, execute stall,
// and a prioritised single-level interrupt controller with return support.
module cpu_seq #(
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned PHASES   = 4,
  parameter int unsigned IRQ_N    = 4,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned IRQ_BASE = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_req,
  input  logic              rom_ready,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic [PHASES-1:0] phase,
  output logic              commit,
  input  logic              ex_stall,
  input  logic [ADDR_W-1:0] ex_next_pc,
  input  logic [IRQ_N-1:0]  irq,
  input  logic              irq_en,
  input  logic              irq_ret,
  output logic [IRQ_N-1:0]  irq_ack,
  output logic              irq_pending,
  output logic              in_isr,
  output logic [ADDR_W-1:0] epc
);

  logic [IRQ_N-1:0]  pending;
  logic [IRQ_N-1:0]  pending_nxt;
  logic [IRQ_N-1:0]  lowest;
  logic [ADDR_W-1:0] irq_vec;
  logic              found;
  logic              take_irq;
  logic [PHASES-1:0] phase_shift;

  assign rom_req     = phase[0];
  assign phase_shift = {phase[PHASES-2:0], 1'b0};

  // Commit strobe, lowest-index interrupt select and pending update
  always_comb begin
    lowest  = '0;
    irq_vec = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < IRQ_N; i++) begin
      if (pending[i] && !found) begin
        found     = 1'b1;
        lowest[i] = 1'b1;
        irq_vec   = ADDR_W'(IRQ_BASE + i);
      end
    end
    commit      = ~reset & phase[PHASES-1] & ~ex_stall;
    take_irq    = commit & ~irq_ret & irq_en & ~in_isr & found;
    irq_ack     = take_irq ? lowest : '0;
    pending_nxt = (pending | irq) & ~irq_ack;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase       <= PHASES'(1);
      rom_addr    <= ADDR_W'(RESET_PC);
      inst        <= '0;
      inst_valid  <= 1'b0;
      pending     <= '0;
      irq_pending <= 1'b0;
      in_isr      <= 1'b0;
      epc         <= '0;
    end else begin
      pending     <= pending_nxt;
      irq_pending <= |pending_nxt;
      if (phase[0]) begin
        if (rom_ready) begin
          inst       <= rom_data;
          inst_valid <= 1'b1;
          phase      <= phase_shift;
        end
      end else if (commit) begin
        phase      <= PHASES'(1);
        inst_valid <= 1'b0;
        if (irq_ret) begin
          rom_addr <= epc;
          in_isr   <= 1'b0;
        end else if (take_irq) begin
          rom_addr <= irq_vec;
          epc      <= ex_next_pc;
          in_isr   <= 1'b1;
        end else begin
          rom_addr <= ex_next_pc;
        end
      end else if (!phase[PHASES-1]) begin
        phase <= phase_shift;
      end
    end
  end

endmodule

// File: tb/tb_cpu_seq.sv
// Bench for cpu_seq: two instances (4-phase/base 16 and 2-phase/base 2047) checked every
// cycle against an abstract model, plus directed scenarios with literal expectations.
module tb_cpu_seq;

  logic        clk;
  logic        reset;
  logic        rom_ready;
  logic [31:0] rom_data;
  logic        ex_stall;
  logic [10:0] ex_next_pc;
  logic [3:0]  irq;
  logic        irq_en;
  logic        irq_ret;

  logic [10:0] a0, a1, epc0, epc1;
  logic        req0, req1, iv0, iv1, c0, c1, ip0, ip1, isr0, isr1;
  logic [31:0] inst0, inst1;
  logic [3:0]  ph0, ack0, ack1;
  logic [1:0]  ph1;

  int n_cmp = 0;
  int n_bad = 0;

  // Abstract model state, index 0 = u0, 1 = u1
  int          m_ph   [2];
  logic [10:0] m_pc   [2];
  logic [10:0] m_epc  [2];
  logic [31:0] m_inst [2];
  logic        m_iv   [2];
  logic        m_isr  [2];
  logic [3:0]  m_pend [2];

  cpu_seq #(.ADDR_W(11), .DATA_W(32), .PHASES(4), .IRQ_N(4), .RESET_PC(0), .IRQ_BASE(16)) u0 (
    .clk(clk), .reset(reset), .rom_addr(a0), .rom_req(req0), .rom_ready(rom_ready),
    .rom_data(rom_data), .inst(inst0), .inst_valid(iv0), .phase(ph0), .commit(c0),
    .ex_stall(ex_stall), .ex_next_pc(ex_next_pc), .irq(irq), .irq_en(irq_en),
    .irq_ret(irq_ret), .irq_ack(ack0), .irq_pending(ip0), .in_isr(isr0), .epc(epc0));

  cpu_seq #(.ADDR_W(11), .DATA_W(32), .PHASES(2), .IRQ_N(4), .RESET_PC(0), .IRQ_BASE(2047)) u1 (
    .clk(clk), .reset(reset), .rom_addr(a1), .rom_req(req1), .rom_ready(rom_ready),
    .rom_data(rom_data), .inst(inst1), .inst_valid(iv1), .phase(ph1), .commit(c1),
    .ex_stall(ex_stall), .ex_next_pc(ex_next_pc), .irq(irq), .irq_en(irq_en),
    .irq_ret(irq_ret), .irq_ack(ack1), .irq_pending(ip1), .in_isr(isr1), .epc(epc1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nph(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic int vbase(input int i);
    return (i == 0) ? 16 : 2047;
  endfunction

  function automatic logic exp_commit(input int i);
    return !reset && (m_ph[i] == nph(i) - 1) && !ex_stall;
  endfunction

  // Lowest set pending bit, isolated arithmetically
  function automatic logic [3:0] exp_ack(input int i);
    if (exp_commit(i) && !irq_ret && irq_en && !m_isr[i] && m_pend[i] != 4'd0)
      return m_pend[i] & (~m_pend[i] + 4'd1);
    return 4'd0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic [10:0] a, input logic rq, input logic [31:0] in,
                          input logic iv, input logic [7:0] ph, input logic c, input logic [3:0] ak,
                          input logic ip, input logic isr, input logic [10:0] ep);
    string p;
    p = $sformatf("u%0d.", i);
    chk({p, "rom_addr"}, a, m_pc[i]);
    chk({p, "rom_req"}, rq, m_ph[i] == 0);
    chk({p, "inst"}, in, m_inst[i]);
    chk({p, "inst_valid"}, iv, m_iv[i]);
    chk({p, "phase"}, ph, 8'(1 << m_ph[i]));
    chk({p, "commit"}, c, exp_commit(i));
    chk({p, "irq_ack"}, ak, exp_ack(i));
    chk({p, "irq_pending"}, ip, m_pend[i] != 4'd0);
    chk({p, "in_isr"}, isr, m_isr[i]);
    chk({p, "epc"}, ep, m_epc[i]);
  endtask

  task automatic model_update();
    logic       c;
    logic [3:0] ak;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_ph[i] = 0; m_pc[i] = 11'd0; m_epc[i] = 11'd0; m_inst[i] = 32'd0;
        m_iv[i] = 1'b0; m_isr[i] = 1'b0; m_pend[i] = 4'd0;
      end else begin
        c  = exp_commit(i);
        ak = exp_ack(i);
        m_pend[i] = (m_pend[i] | irq) & ~ak;
        if (m_ph[i] == 0) begin
          if (rom_ready) begin
            m_inst[i] = rom_data; m_iv[i] = 1'b1; m_ph[i] = 1;
          end
        end else if (m_ph[i] == nph(i) - 1) begin
          if (c) begin
            m_ph[i] = 0; m_iv[i] = 1'b0;
            if (irq_ret) begin
              m_pc[i] = m_epc[i]; m_isr[i] = 1'b0;
            end else if (ak != 4'd0) begin
              m_pc[i] = 11'(vbase(i) + $clog2(ak)); m_epc[i] = ex_next_pc; m_isr[i] = 1'b1;
            end else begin
              m_pc[i] = ex_next_pc;
            end
          end
        end else begin
          m_ph[i] = m_ph[i] + 1;
        end
      end
    end
  endtask

  // One clock: check outputs mid-cycle, advance model at the edge, return just after it
  task automatic step();
    @(negedge clk);
    cmp_inst(0, a0, req0, inst0, iv0, 8'(ph0), c0, ack0, ip0, isr0, epc0);
    cmp_inst(1, a1, req1, inst1, iv1, 8'(ph1), c1, ack1, ip1, isr1, epc1);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  int ack_seen;

  initial begin
    reset = 1'b1; rom_ready = 1'b1; rom_data = 32'd0; ex_stall = 1'b0;
    ex_next_pc = 11'd0; irq = 4'd0; irq_en = 1'b0; irq_ret = 1'b0;
    @(posedge clk); model_update(); #1;
    step();
    reset = 1'b0;

    // PHASES=2, IRQ_BASE=2047: channel 1 vectors to 2048, which wraps to 0
    irq = 4'b0010; irq_en = 1'b1; ex_next_pc = 11'd5;
    step();
    irq = 4'd0;
    #1 chk("wrap_ack", ack1, 4'b0010);
    step();
    chk("wrap_pc", a1, 11'd0);
    chk("wrap_epc", epc1, 11'd5);
    chk("wrap_isr", isr1, 1'b1);

    reset = 1'b1; irq_en = 1'b0; step(); reset = 1'b0;
    chk("rst_phase", ph0, 4'b0001);
    chk("rst_addr", a0, 11'd0);
    chk("rst_valid", iv0, 1'b0);

    // Nominal 4-cycle instruction
    rom_data = 32'hA5A5_0001; ex_next_pc = 11'd1;
    step();
    chk("nom_inst", inst0, 32'hA5A5_0001);
    chk("nom_phase1", ph0, 4'b0010);
    step();
    chk("nom_phase2", ph0, 4'b0100);
    step();
    chk("nom_phase3", ph0, 4'b1000);
    #1 chk("nom_commit", c0, 1'b1);
    step();
    chk("nom_addr", a0, 11'd1);
    chk("nom_valid_drop", iv0, 1'b0);

    // Three ROM wait states, then a two-cycle execute stall
    rom_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("wait_req", req0, 1'b1);
      chk("wait_valid", iv0, 1'b0);
    end
    rom_ready = 1'b1; rom_data = 32'h1234_5678;
    step();
    chk("wait_valid_rise", iv0, 1'b1);
    steps(2);
    ex_stall = 1'b1;
    #1 chk("stall_no_commit", c0, 1'b0);
    steps(2);
    chk("stall_phase", ph0, 4'b1000);
    chk("stall_addr", a0, 11'd1);
    ex_stall = 1'b0; ex_next_pc = 11'd2;
    #1 chk("stall_commit", c0, 1'b1);
    step();
    chk("stall_addr_next", a0, 11'd2);

    // Priority: channels 1 and 3 pending, channel 1 first; return, then channel 3
    irq = 4'b1010; irq_en = 1'b1; ex_next_pc = 11'd9;
    step();
    irq = 4'd0;
    chk("irq_pending", ip0, 1'b1);
    steps(2);
    #1 chk("irq_ack1", ack0, 4'b0010);
    step();
    chk("irq_pc17", a0, 11'd17);
    chk("irq_epc9", epc0, 11'd9);
    chk("irq_isr", isr0, 1'b1);
    chk("irq_keep3", ip0, 1'b1);
    steps(3);
    irq_ret = 1'b1; ex_next_pc = 11'd18;
    #1 chk("ret_wins", ack0, 4'b0000);
    step();
    irq_ret = 1'b0;
    chk("ret_pc9", a0, 11'd9);
    chk("ret_isr", isr0, 1'b0);
    steps(3);
    ex_next_pc = 11'd10;
    #1 chk("irq_ack3", ack0, 4'b1000);
    step();
    chk("irq_pc19", a0, 11'd19);
    chk("irq_epc10", epc0, 11'd10);

    // Leave the handler, then disable interrupts: nothing is acknowledged
    steps(3);
    irq_ret = 1'b1; irq_en = 1'b0;
    step();
    irq_ret = 1'b0; irq = 4'b0001;
    step();
    irq = 4'd0;
    ack_seen = 0;
    for (int k = 0; k < 24; k++) begin
      step();
      if (ack0 != 4'd0) ack_seen++;
    end
    chk("dis_no_ack", 64'(ack_seen), 64'd0);
    chk("dis_pending", ip0, 1'b1);

    // Reset in the middle of a stall while inside a handler with channel 0 pending
    reset = 1'b1; step(); reset = 1'b0;
    irq = 4'b0001; irq_en = 1'b1; ex_next_pc = 11'd3;
    step();
    irq = 4'd0;
    steps(3);
    irq = 4'b0001;
    step();
    irq = 4'd0;
    steps(2);
    ex_stall = 1'b1;
    steps(2);
    chk("pre_rst_isr", isr0, 1'b1);
    chk("pre_rst_pend", ip0, 1'b1);
    chk("pre_rst_phase", ph0, 4'b1000);
    reset = 1'b1;
    step();
    chk("mid_rst_phase", ph0, 4'b0001);
    chk("mid_rst_addr", a0, 11'd0);
    chk("mid_rst_isr", isr0, 1'b0);
    chk("mid_rst_pend", ip0, 1'b0);
    chk("mid_rst_epc", epc0, 11'd0);
    chk("mid_rst_inst", inst0, 32'd0);
    reset = 1'b0; ex_stall = 1'b0; irq_en = 1'b0;
    steps(3);
    #1 chk("fresh_commit", c0, 1'b1);
    step();

    // Randomised traffic against the model
    for (int k = 0; k < 3000; k++) begin
      reset      = ($urandom_range(0, 199) == 0);
      rom_ready  = ($urandom_range(0, 3) != 0);
      rom_data   = $urandom;
      ex_stall   = ($urandom_range(0, 3) == 0);
      ex_next_pc = 11'($urandom);
      irq        = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
      irq_ret    = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 19) == 0) irq_en = ~irq_en;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
